// File: rtl/tmds_period_scheduler.sv
// tmds_period_scheduler: delays the pixel stream by ten stages and places the HDMI preamble and
// guard band ahead of each DE rise, so the words handed to the serializers carry the right periods.
module tmds_period_scheduler #(
  parameter logic [9:0] CTL_00 = 10'b1101010100,
  parameter logic [9:0] CTL_01 = 10'b0010101011,
  parameter logic [9:0] CTL_10 = 10'b0101010100,
  parameter logic [9:0] CTL_11 = 10'b1010101011
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       hdmi_mode,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] enc_word_0,
  input  logic [9:0] enc_word_1,
  input  logic [9:0] enc_word_2,
  output logic [9:0] tmds_word_0,
  output logic [9:0] tmds_word_1,
  output logic [9:0] tmds_word_2,
  output logic       de_out,
  output logic [1:0] period,
  output logic       short_blank_err
);
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [9:0] w0;
    logic [9:0] w1;
    logic [9:0] w2;
  } stage_t;
  typedef enum logic [1:0] {CTRL = 2'd0, PREAMBLE = 2'd1, GUARD = 2'd2, VIDEO = 2'd3} state_t;
  stage_t     pipe_q [10];
  stage_t     tap;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rise, err_d, err_q, de_q;
  logic [1:0] period_d, period_q;
  logic [9:0] w0_d, w1_d, w2_d, w0_q, w1_q, w2_q, ctl_tap;
  assign tap = pipe_q[9];
  assign rise = de_in & ~pipe_q[0].de;
  assign ctl_tap = {tap.vs, tap.hs} == 2'b00 ? CTL_00 :
                   {tap.vs, tap.hs} == 2'b01 ? CTL_01 :
                   {tap.vs, tap.hs} == 2'b10 ? CTL_10 : CTL_11;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 3'd1;
    case (state_q)
      CTRL: begin
        cnt_d = 3'd0;
        if (rise && hdmi_mode) state_d = PREAMBLE;
        else if (tap.de) state_d = VIDEO;
      end
      PREAMBLE: if (cnt_q == 3'd7) begin
        state_d = GUARD;
        cnt_d = 3'd0;
      end
      GUARD: if (cnt_q == 3'd1) begin
        state_d = VIDEO;
        cnt_d = 3'd0;
      end
      default: begin
        cnt_d = 3'd0;
        if (!tap.de) state_d = CTRL;
      end
    endcase
    err_d = err_q | (rise & hdmi_mode & (state_q != CTRL));
    // outputs follow the state being entered so the preamble lands on t+1 after a rise at t
    period_d = tap.de ? 2'd3 : (state_d == VIDEO ? 2'd0 : 2'(state_d));
    w0_d = period_d == 2'd3 ? tap.w0 : period_d == 2'd2 ? GB_A : ctl_tap;
    w1_d = period_d == 2'd3 ? tap.w1 : period_d == 2'd2 ? GB_B : period_d == 2'd1 ? CTL_01 : CTL_00;
    w2_d = period_d == 2'd3 ? tap.w2 : period_d == 2'd2 ? GB_A : CTL_00;
  end
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) pipe_q[i] <= '0;
      state_q <= CTRL;
      cnt_q <= 3'd0;
      err_q <= 1'b0;
      de_q <= 1'b0;
      period_q <= 2'd0;
      w0_q <= CTL_00;
      w1_q <= CTL_00;
      w2_q <= CTL_00;
    end else begin
      pipe_q[0] <= '{de: de_in, hs: hsync_in, vs: vsync_in, w0: enc_word_0, w1: enc_word_1, w2: enc_word_2};
      for (int i = 1; i < 10; i++) pipe_q[i] <= pipe_q[i-1];
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      de_q <= tap.de;
      period_q <= period_d;
      w0_q <= w0_d;
      w1_q <= w1_d;
      w2_q <= w2_d;
    end
  end
  assign tmds_word_0 = w0_q;
  assign tmds_word_1 = w1_q;
  assign tmds_word_2 = w2_q;
  assign de_out = de_q;
  assign period = period_q;
  assign short_blank_err = err_q;
endmodule

// File: tb/tb_tmds_period_scheduler.sv
// tb_tmds_period_scheduler: directed cycle-numbered stimulus; input applied in cycle t is expected
// on the outputs in cycle t+11.
module tb_tmds_period_scheduler;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] GA = 10'b1011001100;
  localparam logic [9:0] GB = 10'b0100110011;
  logic clk = 1'b0;
  logic rst_n, hdmi, de, hs, vs;
  logic [9:0] w0, w1, w2, t0, t1, t2;
  logic de_o, err_o;
  logic [1:0] per_o;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  tmds_period_scheduler dut (
    .pixel_clk(clk), .rst_n(rst_n), .hdmi_mode(hdmi), .de_in(de), .hsync_in(hs), .vsync_in(vs),
    .enc_word_0(w0), .enc_word_1(w1), .enc_word_2(w2),
    .tmds_word_0(t0), .tmds_word_1(t1), .tmds_word_2(t2),
    .de_out(de_o), .period(per_o), .short_blank_err(err_o)
  );
  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  initial begin
    rst_n = 1'b0; hdmi = 1'b0; de = 1'b0; hs = 1'b1; vs = 1'b0; w0 = '0; w1 = '0; w2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ch0", t0, C00); chk("rst_ch1", t1, C00); chk("rst_ch2", t2, C00);
    chk("rst_de", 10'(de_o), 10'd0); chk("rst_period", 10'(per_o), 10'd0); chk("rst_err", 10'(err_o), 10'd0);
    rst_n = 1'b1;
    // DVI burst at 100..103
    at(50);  chk("dvi_blank_ch0", t0, C01); chk("dvi_blank_ch1", t1, C00); chk("dvi_blank_per", 10'(per_o), 10'd0);
    at(100); de = 1'b1; w0 = 10'h155; w1 = 10'h2AA; w2 = 10'h0F0;
    at(104); de = 1'b0;
    at(105); chk("dvi_nopre_per", 10'(per_o), 10'd0); chk("dvi_nopre_ch1", t1, C00);
    at(110); chk("dvi_pre_de", 10'(de_o), 10'd0); chk("dvi_pre_ch0", t0, C01);
    at(111); chk("dvi_v0_de", 10'(de_o), 10'd1); chk("dvi_v0_ch0", t0, 10'h155); chk("dvi_v0_per", 10'(per_o), 10'd3);
    at(114); chk("dvi_v3_de", 10'(de_o), 10'd1); chk("dvi_v3_ch0", t0, 10'h155);
    at(115); chk("dvi_end_de", 10'(de_o), 10'd0); chk("dvi_end_ch0", t0, C01);
    // HDMI burst at 200..229 after long blank
    at(150); hdmi = 1'b1; hs = 1'b0; vs = 1'b1;
    at(200); chk("h_ctl_per", 10'(per_o), 10'd0); chk("h_ctl_ch0", t0, C10);
    de = 1'b1; w0 = 10'h3C3; w1 = 10'h1E1; w2 = 10'h0C3;
    at(201); chk("pre0_per", 10'(per_o), 10'd1); chk("pre0_ch0", t0, C10); chk("pre0_ch1", t1, C01);
    chk("pre0_ch2", t2, C00); chk("pre0_de", 10'(de_o), 10'd0);
    at(208); chk("pre7_per", 10'(per_o), 10'd1); chk("pre7_ch1", t1, C01);
    at(209); chk("gb0_per", 10'(per_o), 10'd2); chk("gb0_ch0", t0, GA); chk("gb0_ch1", t1, GB); chk("gb0_ch2", t2, GA);
    at(210); chk("gb1_per", 10'(per_o), 10'd2);
    at(211); chk("hv_per", 10'(per_o), 10'd3); chk("hv_de", 10'(de_o), 10'd1);
    chk("hv_ch0", t0, 10'h3C3); chk("hv_ch1", t1, 10'h1E1); chk("hv_ch2", t2, 10'h0C3);
    // short blank: fall at 230, rise at 235
    at(230); chk("err_before", 10'(err_o), 10'd0); de = 1'b0;
    at(235); de = 1'b1; w0 = 10'h2D2;
    at(236); chk("err_set", 10'(err_o), 10'd1);
    at(240); chk("b1_last_de", 10'(de_o), 10'd1); chk("b1_last_ch0", t0, 10'h3C3);
    at(241); chk("sb_de", 10'(de_o), 10'd0); chk("sb_per", 10'(per_o), 10'd0); chk("sb_ch1", t1, C00);
    at(245); chk("sb_end_per", 10'(per_o), 10'd0); chk("sb_end_ch1", t1, C00); de = 1'b0;
    at(246); chk("b2_de", 10'(de_o), 10'd1); chk("b2_per", 10'(per_o), 10'd3); chk("b2_ch0", t0, 10'h2D2);
    at(255); chk("b2_last_de", 10'(de_o), 10'd1);
    at(256); chk("b2_end_de", 10'(de_o), 10'd0);
    // 3-cycle DE pulse
    at(300); de = 1'b1; w0 = 10'h111;
    at(303); de = 1'b0;
    at(305); chk("p3_pre_per", 10'(per_o), 10'd1);
    at(310); chk("p3_gb_per", 10'(per_o), 10'd2);
    at(311); chk("p3_v_per", 10'(per_o), 10'd3); chk("p3_v_ch0", t0, 10'h111);
    at(313); chk("p3_vlast_de", 10'(de_o), 10'd1);
    at(314); chk("p3_end_de", 10'(de_o), 10'd0); chk("p3_end_per", 10'(per_o), 10'd0);
    chk("p3_end_ch0", t0, C10); chk("p3_end_ch1", t1, C00); chk("err_sticky", 10'(err_o), 10'd1);
    // hdmi_mode drops mid-preamble
    at(400); de = 1'b1; w0 = 10'h0AB;
    at(403); hdmi = 1'b0;
    at(404); chk("tg_pre_per", 10'(per_o), 10'd1);
    at(408); chk("tg_pre7_per", 10'(per_o), 10'd1);
    at(409); chk("tg_gb_per", 10'(per_o), 10'd2);
    at(410); chk("tg_gb1_per", 10'(per_o), 10'd2); de = 1'b0;
    at(411); chk("tg_v_per", 10'(per_o), 10'd3); chk("tg_v_ch0", t0, 10'h0AB);
    at(420); chk("tg_vlast_de", 10'(de_o), 10'd1);
    at(421); chk("tg_end_de", 10'(de_o), 10'd0);
    at(450); de = 1'b1; w0 = 10'h099;
    at(451); chk("dvi2_nopre_per", 10'(per_o), 10'd0); chk("dvi2_nopre_ch1", t1, C00);
    at(460); chk("dvi2_pre_de", 10'(de_o), 10'd0); de = 1'b0;
    at(461); chk("dvi2_v_per", 10'(per_o), 10'd3); chk("dvi2_v_ch0", t0, 10'h099);
    // asynchronous reset mid-video
    at(465); chk("mid_video_de", 10'(de_o), 10'd1);
    #3 rst_n = 1'b0; hs = 1'b1; vs = 1'b0;
    #1;
    chk("arst_ch0", t0, C00); chk("arst_ch1", t1, C00); chk("arst_ch2", t2, C00);
    chk("arst_de", 10'(de_o), 10'd0); chk("arst_per", 10'(per_o), 10'd0); chk("arst_err", 10'(err_o), 10'd0);
    at(467); rst_n = 1'b1;
    at(468); chk("post_rst_ch0", t0, C00);
    at(477); chk("post_rst_ch0_late", t0, C00);
    at(478); chk("post_rst_new_ch0", t0, C01);
    // DVI short blank must not flag an error
    at(480); de = 1'b1; w0 = 10'h3FF;
    at(495); de = 1'b0;
    at(497); de = 1'b1; w0 = 10'h200;
    at(500); de = 1'b0;
    at(505); chk("dsb_v1_de", 10'(de_o), 10'd1); chk("dsb_v1_ch0", t0, 10'h3FF);
    at(506); chk("dsb_gap_de", 10'(de_o), 10'd0); chk("dsb_gap_ch0", t0, C01); chk("dsb_gap_per", 10'(per_o), 10'd0);
    at(508); chk("dsb_v2_de", 10'(de_o), 10'd1); chk("dsb_v2_ch0", t0, 10'h200);
    at(511); chk("dsb_end_de", 10'(de_o), 10'd0); chk("dsb_err", 10'(err_o), 10'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/tmds_period_scheduler.md
Name: tmds_period_scheduler

Overview:
- Pixel-clock-domain sequencer that builds the three 10-bit TMDS channel words consumed by the per-channel 10:1 serializers.
- Selects, per pixel cycle, between control-period tokens, HDMI video preamble, video guard band, and TMDS-encoded video words.
- Delays all inputs through a fixed 10-stage pipeline so the 8-cycle preamble and 2-cycle guard band can be inserted ahead of each DE rising edge.
- Sits between the TMDS encoders / timing generator and the serializers.

Parameters:
- CTL_00, 10'b1101010100, control token for {c1,c0}=00
- CTL_01, 10'b0010101011, control token for {c1,c0}=01
- CTL_10, 10'b0101010100, control token for {c1,c0}=10
- CTL_11, 10'b1010101011, control token for {c1,c0}=11

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- hdmi_mode  in  1  1 = HDMI (insert preamble and guard), 0 = DVI (control and video only)
- de_in  in  1  data enable, aligned with enc_word_*
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- enc_word_0  in  10  TMDS-encoded blue word
- enc_word_1  in  10  TMDS-encoded green word
- enc_word_2  in  10  TMDS-encoded red word
- tmds_word_0  out  10  channel 0 word to serializer
- tmds_word_1  out  10  channel 1 word to serializer
- tmds_word_2  out  10  channel 2 word to serializer
- de_out  out  1  delayed DE, aligned with tmds_word_*
- period  out  2  0=control, 1=preamble, 2=guard, 3=video; aligned with words
- short_blank_err  out  1  sticky; set when a DE rise cannot receive a preamble

Behaviour:
- Reset (async assert, sync release):
  - All pipeline stages cleared.
  - tmds_word_0/1/2 = CTL_00, de_out=0, period=0, short_blank_err=0, FSM in CTRL, counter=0.
- Pipeline:
  - Stages d1..d10 carry {de, hsync, vsync, enc_word_0..2}.
  - An output register follows d10.
  - Input sampled at cycle t appears on outputs at t+11. Latency is fixed and identical in both modes.
- Rising-edge detect: rise = de_in & ~d1.de, evaluated on the input side, 10 cycles ahead of the d10 tap.
- FSM states: CTRL, PREAMBLE, GUARD, VIDEO.
  - CTRL -> PREAMBLE when rise & hdmi_mode. Counter loads 0.
  - PREAMBLE lasts 8 cycles (counter 0..7), then -> GUARD.
  - GUARD lasts 2 cycles (counter 0..1), then -> VIDEO.
  - VIDEO -> CTRL on the cycle d10.de=0 is sampled (first blank word at output).
  - CTRL -> VIDEO directly when d10.de=1 (DVI mode, or a DE rise that received no preamble).
- Output word selection (registered):
  - d10.de=1: video state; words = d10.enc_word_0..2; de_out=1.
  - PREAMBLE:
    - ch0 = CTL_{vsync,hsync} from d10.
    - ch1 = CTL_01.
    - ch2 = CTL_00.
  - GUARD:
    - ch0 = 10'b1011001100.
    - ch1 = 10'b0100110011.
    - ch2 = 10'b1011001100.
  - CTRL:
    - ch0 = CTL_{vsync,hsync} from d10.
    - ch1 = CTL_00.
    - ch2 = CTL_00.
  - de_out=0 in every non-video case.
- Alignment guarantee: the preamble occupies output cycles t+1..t+8 and the guard t+9..t+10. The first video word is at t+11, where t is the rise cycle.
- Boundary conditions:
  - A rise seen while FSM is not CTRL (blanking shorter than ~11 cycles) inserts no preamble or guard. Video words are still emitted when d10.de=1, and short_blank_err is set (sticky until reset).
  - A DE pulse shorter than 10 cycles does not abort the preamble or guard sequence. Video is emitted only while d10.de=1.
  - hdmi_mode is sampled only on the CTRL->PREAMBLE decision. A change mid-sequence has no effect until the next CTRL state.
  - rst_n asserted mid-sequence immediately forces the reset values. After release, the first output reflects the cleared pipeline (CTL_00).
  - A rise with hdmi_mode=0 never sets short_blank_err.

Test Plan:
1. Reset with rst_n=0 mid-video -> outputs immediately 10'b1101010100 on all channels, de_out=0, period=0, short_blank_err=0.
2. DVI mode, hsync=1, vsync=0, DE low, then DE high at cycle 100 for 4 cycles with enc_word_0=10'h155 -> ch0=CTL_01 (0010101011) during blanking; 10'h155 and de_out=1 exactly at cycles 111..114; no preamble.
3. HDMI mode, DE rise at cycle 200 after 50 blank cycles -> ch1=0010101011 and ch2=1101010100 at 201..208; guard words 1011001100/0100110011/1011001100 at 209..210; video at 211; period sequence 1,2,3.
4. HDMI mode, DE falls then rises again 5 cycles later -> second burst has no preamble/guard, video aligned at rise+11, short_blank_err=1 and remains 1.
5. HDMI mode, DE pulse of 3 cycles -> full 8+2 preamble/guard, 3 video words, then CTRL tokens; period returns to 0.
6. hdmi_mode toggled 1->0 during preamble -> sequence completes unchanged; next DE rise produces no preamble.
